dual_port_mem_responder: RTL and testbench
==========================================

Name: dual_port_mem_responder

Overview:
- Memory-side responder for the CPU controller's two RAM ports.
- Port 1 serves instruction fetches (read-only) and port 2 serves LDR/STR data accesses (read/write).
- Returns read data after a fixed, pipelined latency that matches the controller's fetch1/fetch2 and mem1/mem2 wait cycles.
- Sits between the controller/datapath and the on-chip 2K-word RAM array.

Parameters:
- ADDR_W, 11: word address width on both ports.
- DATA_W, 32: data word width.
- DEPTH, 2048: number of words implemented; must be <= 2**ADDR_W.
- RD_LAT, 2: read latency in cycles, from the request-sampling edge to rvalid; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req1  in  1  port-1 read request, sampled on the rising edge.
- addr1  in  ADDR_W  port-1 word address (fed by the controller's ram_addr1).
- rdata1  out  DATA_W  port-1 read data, registered.
- rvalid1  out  1  one-cycle pulse: rdata1 holds new data.
- req2  in  1  port-2 request, sampled on the rising edge.
- we2  in  1  port-2 write enable (fed by ram_w_en2); qualifies req2.
- addr2  in  ADDR_W  port-2 word address (fed by ram_addr2).
- wdata2  in  DATA_W  port-2 write data.
- rdata2  out  DATA_W  port-2 read data, registered.
- rvalid2  out  1  one-cycle pulse for port-2 read data.
- wack2  out  1  one-cycle pulse, the cycle after a write commits.
- oob_err  out  1  sticky flag: an access with addr >= DEPTH was seen.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - rdata1 = rdata2 = 0; rvalid1 = rvalid2 = wack2 = oob_err = 0.
  - All latency pipeline stages invalid.
  - RAM contents are NOT reset and are preserved across reset.
- Reset mid-operation drops in-flight reads; no rvalid is produced for them after reset releases.
- Port-1 read:
  - req1 sampled high at edge t gives rvalid1 high for exactly the cycle after edge t+RD_LAT-1, i.e. the pulse is visible after RD_LAT edges.
  - rdata1 is updated on the same edge and held until the next rvalid1.
- Port-2 read (req2=1, we2=0): identical rule, using rdata2/rvalid2.
- Port-2 write (req2=1, we2=1):
  - mem[addr2] <= wdata2 at the sampling edge.
  - wack2 pulses in the following cycle.
  - No rvalid2 is generated.
- Full pipelining, no backpressure: one request per port per cycle. Back-to-back requests produce back-to-back rvalid pulses in request order.
- we2 with req2=0 is ignored.
- Same-port ordering: a write at edge t followed by a read of the same address at edge t+1 returns the new data.
- Cross-port collision (port-1 read and port-2 write to the same address at the same edge): see Optional Feature.
- Simultaneous port-2 reads and port-1 reads to any addresses are always legal.
- Out of range (addr >= DEPTH):
  - Reads still produce rvalid, with data 0.
  - Writes are dropped; wack2 still pulses.
  - oob_err sets and stays set until reset.
- Arithmetic: no address wrap; comparison is unsigned against DEPTH.
- State: the per-port valid shift register is RD_LAT deep; the data register is sampled at the stage RD_LAT-1 output. There is no FSM beyond the pipeline valid bits.

Optional Feature:
- Macro MEM_BYPASS_EN.
- Defined: on a cross-port collision, port 1 returns wdata2 (write-first forwarding). Forwarding also covers a port-2 write to an address already in flight in the port-1 pipeline: the youngest write wins.
- Undefined: port 1 returns the pre-write contents (read-before-write). Any read already in flight is unaffected by later writes.

Decomposition:
- Package mem_pkg:
  - ADDR_W / DATA_W constants.
  - addr_t and word_t typedefs.
  - mem_req_t struct {req, we, addr, wdata}.
  - Latency bounds LAT_MIN = 1 and LAT_MAX = 4.
- One sub-module, mem_lat_pipe: parameterised valid/address shift pipeline, instantiated once per port.

Test Plan:
1. Reset, write mem[5] = 0xDEADBEEF on port 2, read addr1 = 5 at the next edge, RD_LAT = 2 -> wack2 one cycle after the write, rvalid1 two edges after the read, rdata1 = 0xDEADBEEF.
2. req1 on 4 consecutive cycles to addrs 0..3, preloaded with 0x10..0x13 -> 4 consecutive rvalid1 pulses with data 0x10, 0x11, 0x12, 0x13 in order.
3. Same-edge port-1 read and port-2 write of addr 7 (old 0x1, new 0x2) -> rdata1 = 0x1 without MEM_BYPASS_EN, 0x2 with it; mem[7] = 0x2 afterwards in both builds.
4. Issue a port-2 read of addr 9, assert rst_n = 0 one cycle later, release -> no rvalid2 ever appears for that read; mem[9] is unchanged on re-read.
5. DEPTH = 1024: write addr 1500 then read addr 1500 -> wack2 pulses, rvalid2 with rdata2 = 0, oob_err = 1 and stays set until reset.
6. RD_LAT = 1 and RD_LAT = 4 builds: a single read -> rvalid after exactly 1 or 4 edges respectively.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths, latency bounds and request types for the dual-port memory responder.
// Latency: none; constants and types only.
// Backpressure: none; constants and types only.
package mem_pkg;

    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 32;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        logic  req;
        logic  we;
        addr_t addr;
        word_t wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_lat_pipe.sv
// Read-latency pipeline: carries valid, address and captured read data through LAT stages.
// Latency: o_vld/o_dat update LAT edges after i_vld is sampled (LAT=1 -> on the sampling edge).
// Backpressure: none; accepts a new entry every cycle, optional snoop lets a younger write replace in-flight data.
module mem_lat_pipe #(
    parameter int AW    = mem_pkg::ADDR_W,
    parameter int DW    = mem_pkg::DATA_W,
    parameter int LAT   = 2,
    parameter bit SNOOP = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vld,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_dat,
    input  logic          i_wr_vld,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_dat,
    output logic          o_vld,
    output logic [DW-1:0] o_dat
);
    import mem_pkg::*;

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        logic          w_vld;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_dat;
        logic          w_hit;
        logic          r_vld;
        logic [DW-1:0] r_dat;

        if (k == 0) begin : g_head
            assign w_vld  = i_vld;
            assign w_addr = i_addr;
            assign w_dat  = i_dat;
        end else begin : g_tail
            assign w_vld  = g_stage[k-1].r_vld;
            assign w_addr = g_stage[k-1].g_addr.r_addr;
            assign w_dat  = g_stage[k-1].r_dat;
        end

        // A write committing on the same edge as this stage loads is younger than the captured data.
        assign w_hit = SNOOP && i_wr_vld && (i_wr_addr == w_addr);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_dat <= '0;
            end else begin
                r_vld <= w_vld;
                if (w_vld) begin
                    r_dat <= w_hit ? i_wr_dat : w_dat;
                end
            end
        end

        if (k < LAT - 1) begin : g_addr
            logic [AW-1:0] r_addr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_addr <= '0;
                end else if (w_vld) begin
                    r_addr <= w_addr;
                end
            end
        end
    end

    assign o_vld = g_stage[LAT-1].r_vld;
    assign o_dat = g_stage[LAT-1].r_dat;

endmodule

// File: rtl/dual_port_mem_responder.sv
// Two-port RAM responder: port 1 fetch reads, port 2 data reads/writes; MEM_BYPASS_EN forwards port-2 writes into port-1 reads.
// Latency: read data and rvalid after RD_LAT edges, wack2 the cycle after a write commits.
// Backpressure: none; one request per port per cycle, fully pipelined and returned in order.
module dual_port_mem_responder #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int DEPTH  = 2048,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    input  logic              req2,
    input  logic              we2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata2,
    output logic [DATA_W-1:0] rdata2,
    output logic              rvalid2,
    output logic              wack2,
    output logic              oob_err
);
    import mem_pkg::*;

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
`ifdef MEM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    if (RD_LAT < LAT_MIN || RD_LAT > LAT_MAX || DEPTH > 2**ADDR_W) begin : g_bad_cfg
        $error("dual_port_mem_responder: RD_LAT must be 1..4 and DEPTH <= 2**ADDR_W");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_wack2;
    logic              r_oob_err;

    mem_req_t          w_req2;
    logic              w_oob1;
    logic              w_oob2;
    logic              w_wr2;
    logic              w_wr2_ok;
    logic              w_rd2;
    logic [IDX_W-1:0]  w_idx1;
    logic [IDX_W-1:0]  w_idx2;
    logic [DATA_W-1:0] w_mem1;
    logic [DATA_W-1:0] w_mem2;

    assign w_req2   = '{req: req2, we: we2, addr: addr2, wdata: wdata2};
    assign w_oob1   = {1'b0, addr1} >= DEPTH_V;
    assign w_oob2   = {1'b0, w_req2.addr} >= DEPTH_V;
    assign w_wr2    = w_req2.req & w_req2.we;
    assign w_wr2_ok = w_wr2 & ~w_oob2;
    assign w_rd2    = w_req2.req & ~w_req2.we;
    assign w_idx1   = addr1[IDX_W-1:0];
    assign w_idx2   = w_req2.addr[IDX_W-1:0];

    // Array is read on the request edge, before that edge's write lands; out-of-range reads return zero.
    assign w_mem1 = w_oob1 ? '0 : r_mem[w_idx1];
    assign w_mem2 = w_oob2 ? '0 : r_mem[w_idx2];

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_wr2_ok) begin
            r_mem[w_idx2] <= w_req2.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wack2   <= 1'b0;
            r_oob_err <= 1'b0;
        end else begin
            r_wack2   <= w_wr2;
            r_oob_err <= r_oob_err | (req1 & w_oob1) | (w_req2.req & w_oob2);
        end
    end

    mem_lat_pipe #(
        .AW    (ADDR_W),
        .DW    (DATA_W),
        .LAT   (RD_LAT),
        .SNOOP (BYPASS)
    ) u_pipe1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_vld     (req1),
        .i_addr    (addr1),
        .i_dat     (w_mem1),
        .i_wr_vld  (w_wr2_ok),
        .i_wr_addr (w_req2.addr),
        .i_wr_dat  (w_req2.wdata),
        .o_vld     (rvalid1),
        .o_dat     (rdata1)
    );

    mem_lat_pipe #(
        .AW    (ADDR_W),
        .DW    (DATA_W),
        .LAT   (RD_LAT),
        .SNOOP (1'b0)
    ) u_pipe2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_vld     (w_rd2),
        .i_addr    (addr2),
        .i_dat     (w_mem2),
        .i_wr_vld  (1'b0),
        .i_wr_addr ('0),
        .i_wr_dat  ('0),
        .o_vld     (rvalid2),
        .o_dat     (rdata2)
    );

    assign wack2   = r_wack2;
    assign oob_err = r_oob_err;

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Bench for dual_port_mem_responder: three instances (RD_LAT 1, 2, 4, DEPTH 1024) share one stimulus stream.
// A queue-based reference model predicts every output from the read/write ordering rules.
module tb_dual_port_mem_responder;
    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int N     = 3;
`ifdef MEM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req1 = 1'b0;
    logic          req2 = 1'b0;
    logic          we2 = 1'b0;
    logic [AW-1:0] addr1 = '0;
    logic [AW-1:0] addr2 = '0;
    logic [DW-1:0] wdata2 = '0;

    logic          v1 [N];
    logic          v2 [N];
    logic          wk [N];
    logic          oe [N];
    logic [DW-1:0] d1 [N];
    logic [DW-1:0] d2 [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        dual_port_mem_responder #(
            .ADDR_W (AW),
            .DATA_W (DW),
            .DEPTH  (DEPTH),
            .RD_LAT (L)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .req1    (req1),
            .addr1   (addr1),
            .rdata1  (d1[g]),
            .rvalid1 (v1[g]),
            .req2    (req2),
            .we2     (we2),
            .addr2   (addr2),
            .wdata2  (wdata2),
            .rdata2  (d2[g]),
            .rvalid2 (v2[g]),
            .wack2   (wk[g]),
            .oob_err (oe[g])
        );
    end

    // Reference model: pending reads carry their due edge; memory is an associative array.
    typedef struct {
        int          dut;
        bit          p1;
        int          due;
        int          addr;
        bit          oob;
        logic [31:0] snap;
    } rd_t;

    rd_t         pend [$];
    logic [31:0] mref [int];
    int          n_edge = 0;
    logic        e_v1 [N];
    logic        e_v2 [N];
    logic [31:0] e_d1 [N];
    logic [31:0] e_d2 [N];
    logic        e_wack = 1'b0;
    logic        e_oob = 1'b0;
    int          checks = 0;
    int          failures = 0;

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    task automatic model_clear();
        pend.delete();
        e_wack = 1'b0;
        e_oob  = 1'b0;
        for (int i = 0; i < N; i++) begin
            e_v1[i] = 1'b0; e_v2[i] = 1'b0; e_d1[i] = '0; e_d2[i] = '0;
        end
    endtask

    task automatic model_edge();
        bit  o1, o2;
        rd_t r;
        n_edge++;
        o1 = int'(addr1) >= DEPTH;
        o2 = int'(addr2) >= DEPTH;
        for (int i = 0; i < N; i++) begin
            e_v1[i] = 1'b0;
            e_v2[i] = 1'b0;
            if (req1) begin
                r.dut = i; r.p1 = 1'b1; r.due = n_edge + lat_of(i) - 1;
                r.addr = int'(addr1); r.oob = o1; r.snap = o1 ? 32'd0 : mref[int'(addr1)];
                pend.push_back(r);
            end
            if (req2 && !we2) begin
                r.dut = i; r.p1 = 1'b0; r.due = n_edge + lat_of(i) - 1;
                r.addr = int'(addr2); r.oob = o2; r.snap = o2 ? 32'd0 : mref[int'(addr2)];
                pend.push_back(r);
            end
        end
        if (req2 && we2 && !o2) mref[int'(addr2)] = wdata2;
        e_wack = req2 && we2;
        if ((req1 && o1) || (req2 && o2)) e_oob = 1'b1;
        for (int k = pend.size() - 1; k >= 0; k--) begin
            if (pend[k].due == n_edge) begin
                r = pend[k];
                if (r.p1) begin
                    e_v1[r.dut] = 1'b1;
                    // Forwarding: port 1 sees memory as it stands after its delivery edge.
                    e_d1[r.dut] = (BYP && !r.oob) ? mref[r.addr] : r.snap;
                end else begin
                    e_v2[r.dut] = 1'b1;
                    e_d2[r.dut] = r.snap;
                end
                pend.delete(k);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        req1 = 1'b0; req2 = 1'b0; we2 = 1'b0;
    endtask

    task automatic do_reset(int edges);
        idle();
        rst_n = 1'b0;
        model_clear();
        repeat (edges) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(3);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (v1[i] !== 1'b0 || v2[i] !== 1'b0 || wk[i] !== 1'b0 || oe[i] !== 1'b0 ||
                d1[i] !== 32'd0 || d2[i] !== 32'd0) begin
                failures++;
                $display("FAIL reset dut%0d: rvalid1=%b rvalid2=%b wack2=%b oob_err=%b rdata1=%h rdata2=%h, required all zero",
                         i, v1[i], v2[i], wk[i], oe[i], d1[i], d2[i]);
            end
        end
    endtask

    task automatic test_preload();
        for (int a = 0; a < 16; a++) begin
            req2 = 1'b1; we2 = 1'b1; addr2 = AW'(a);
            wdata2 = (a < 4) ? 32'h10 + 32'(a) : (a == 7) ? 32'h1 : $urandom;
            tick();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (wk[i] !== 1'b1 || v2[i] !== 1'b0) begin
                    failures++;
                    $display("FAIL preload_wack dut%0d addr %0d: wack2=%b rvalid2=%b, required wack2=1 rvalid2=0", i, a, wk[i], v2[i]);
                end
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        req2 = 1'b1; we2 = 1'b1; addr2 = AW'(5); wdata2 = 32'hDEADBEEF;
        tick();
        idle();
        req1 = 1'b1; addr1 = AW'(5);
        for (int k = 1; k <= 5; k++) begin
            tick();
            idle();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (wk[i] !== (k == 1) ? 1'b0 : 1'b0) begin
                    failures++;
                    $display("FAIL wr_rd_wack dut%0d edge %0d: wack2=%b, required 0", i, k, wk[i]);
                end
                checks++;
                if (v1[i] !== (k == lat_of(i)) || (k == lat_of(i) && d1[i] !== 32'hDEADBEEF)) begin
                    failures++;
                    $display("FAIL wr_rd_latency dut%0d edge %0d: rvalid1=%b rdata1=%h, required rvalid1=%b rdata1=deadbeef",
                             i, k, v1[i], d1[i], k == lat_of(i));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int cnt [N];
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int k = 0; k < 10; k++) begin
            req1  = (k < 4);
            addr1 = (k < 4) ? AW'(k) : '0;
            tick();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (v1[i] !== e_v1[i] || d1[i] !== e_d1[i]) begin
                    failures++;
                    $display("FAIL b2b_model dut%0d edge %0d: rvalid1=%b rdata1=%h, required %b %h", i, k, v1[i], d1[i], e_v1[i], e_d1[i]);
                end
                if (v1[i]) begin
                    checks++;
                    if (d1[i] !== 32'h10 + 32'(cnt[i])) begin
                        failures++;
                        $display("FAIL b2b_order dut%0d pulse %0d: rdata1=%h, required %h", i, cnt[i], d1[i], 32'h10 + 32'(cnt[i]));
                    end
                    cnt[i]++;
                end
            end
        end
        idle();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (cnt[i] != 4) begin
                failures++;
                $display("FAIL b2b_count dut%0d: pulses=%0d, required 4", i, cnt[i]);
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] want;
        want = BYP ? 32'h2 : 32'h1;
        req1 = 1'b1; addr1 = AW'(7);
        req2 = 1'b1; we2 = 1'b1; addr2 = AW'(7); wdata2 = 32'h2;
        for (int k = 1; k <= 5; k++) begin
            tick();
            idle();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (v1[i] !== (k == lat_of(i)) || (k == lat_of(i) && (d1[i] !== want || d1[i] !== e_d1[i]))) begin
                    failures++;
                    $display("FAIL collision_rd1 dut%0d edge %0d: rvalid1=%b rdata1=%h, required rvalid1=%b rdata1=%h",
                             i, k, v1[i], d1[i], k == lat_of(i), want);
                end
            end
        end
        req2 = 1'b1; we2 = 1'b0; addr2 = AW'(7);
        for (int k = 1; k <= 5; k++) begin
            tick();
            idle();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (v2[i] !== (k == lat_of(i)) || (k == lat_of(i) && d2[i] !== 32'h2)) begin
                    failures++;
                    $display("FAIL collision_mem dut%0d edge %0d: rvalid2=%b rdata2=%h, required rvalid2=%b rdata2=2",
                             i, k, v2[i], d2[i], k == lat_of(i));
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        req2 = 1'b1; we2 = 1'b0; addr2 = AW'(9);
        tick();
        idle();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (v2[i] !== e_v2[i] || d2[i] !== e_d2[i]) begin
                failures++;
                $display("FAIL inflight_pre dut%0d: rvalid2=%b rdata2=%h, required %b %h", i, v2[i], d2[i], e_v2[i], e_d2[i]);
            end
        end
        rst_n = 1'b0;
        model_clear();
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (v2[i] !== 1'b0 || d2[i] !== 32'd0) begin
                failures++;
                $display("FAIL inflight_async dut%0d: rvalid2=%b rdata2=%h, required 0 0", i, v2[i], d2[i]);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (v2[i] !== 1'b0) begin
                    failures++;
                    $display("FAIL inflight_dropped dut%0d edge %0d: rvalid2=%b, required 0", i, k, v2[i]);
                end
            end
        end
        req2 = 1'b1; we2 = 1'b0; addr2 = AW'(9);
        for (int k = 1; k <= 5; k++) begin
            tick();
            idle();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (v2[i] !== (k == lat_of(i)) || (k == lat_of(i) && d2[i] !== mref[9])) begin
                    failures++;
                    $display("FAIL inflight_reread dut%0d edge %0d: rvalid2=%b rdata2=%h, required rvalid2=%b rdata2=%h",
                             i, k, v2[i], d2[i], k == lat_of(i), mref[9]);
                end
            end
        end
    endtask

    task automatic test_oob();
        logic [31:0] w;
        w = $urandom;
        req2 = 1'b1; we2 = 1'b1; addr2 = AW'(DEPTH - 1); wdata2 = w;
        tick();
        req2 = 1'b0; we2 = 1'b0; req1 = 1'b1; addr1 = AW'(DEPTH - 1);
        tick();
        idle();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (oe[i] !== 1'b0) begin
                failures++;
                $display("FAIL oob_edge_inrange dut%0d: oob_err=%b, required 0", i, oe[i]);
            end
        end
        repeat (4) tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (d1[i] !== w) begin
                failures++;
                $display("FAIL oob_last_word dut%0d: rdata1=%h, required %h", i, d1[i], w);
            end
        end
        req2 = 1'b1; we2 = 1'b1; addr2 = AW'(1500); wdata2 = $urandom;
        tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (wk[i] !== 1'b1 || oe[i] !== 1'b1) begin
                failures++;
                $display("FAIL oob_write dut%0d: wack2=%b oob_err=%b, required 1 1", i, wk[i], oe[i]);
            end
        end
        req2 = 1'b1; we2 = 1'b0; addr2 = AW'(1500);
        for (int k = 1; k <= 5; k++) begin
            tick();
            idle();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (v2[i] !== (k == lat_of(i)) || (k == lat_of(i) && d2[i] !== 32'd0) || oe[i] !== 1'b1) begin
                    failures++;
                    $display("FAIL oob_read dut%0d edge %0d: rvalid2=%b rdata2=%h oob_err=%b, required rvalid2=%b rdata2=0 oob_err=1",
                             i, k, v2[i], d2[i], oe[i], k == lat_of(i));
                end
            end
        end
        do_reset(2);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (oe[i] !== 1'b0) begin
                failures++;
                $display("FAIL oob_cleared dut%0d: oob_err=%b, required 0", i, oe[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req1   = ($urandom_range(0, 2) != 0);
            addr1  = ($urandom_range(0, 15) == 0) ? AW'(DEPTH + $urandom_range(0, 1023)) : AW'($urandom_range(0, 15));
            req2   = ($urandom_range(0, 2) != 0);
            we2    = $urandom_range(0, 1) == 1;
            addr2  = ($urandom_range(0, 15) == 0) ? AW'(DEPTH + $urandom_range(0, 1023)) : AW'($urandom_range(0, 15));
            wdata2 = $urandom;
            tick();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (v1[i] !== e_v1[i] || d1[i] !== e_d1[i] || v2[i] !== e_v2[i] || d2[i] !== e_d2[i] ||
                    wk[i] !== e_wack || oe[i] !== e_oob) begin
                    failures++;
                    $display("FAIL random dut%0d cycle %0d: got v1=%b d1=%h v2=%b d2=%h wack=%b oob=%b, required v1=%b d1=%h v2=%b d2=%h wack=%b oob=%b",
                             i, c, v1[i], d1[i], v2[i], d2[i], wk[i], oe[i],
                             e_v1[i], e_d1[i], e_v2[i], e_d2[i], e_wack, e_oob);
                end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_preload();
        test_write_read();
        test_back_to_back();
        test_collision();
        test_reset_inflight();
        test_oob();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
